// File: rtl/logic_unit_arbiter.sv
// Round-robin shared bitwise logic unit (AND/OR/XOR/NOR) for NREQ requesters, with a
// one-entry registered result slot drained through a valid/ready handshake.
module logic_unit_arbiter #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned NREQ  = 4,
  localparam int unsigned IDW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] opA,
  input  logic [NREQ*WIDTH-1:0] opB,
  input  logic [NREQ*2-1:0]     opSel,
  output logic [NREQ-1:0]       gnt,
  output logic                  resValid,
  input  logic                  resReady,
  output logic [IDW-1:0]        resId,
  output logic [WIDTH-1:0]      result
);

  typedef enum logic [0:0] {StEmpty, StFull} slot_state_e;

  slot_state_e      state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [IDW-1:0]   res_id_q, res_id_d;
  logic [IDW-1:0]   ptr_q, ptr_d;

  logic [WIDTH-1:0] op_a   [NREQ];
  logic [WIDTH-1:0] op_b   [NREQ];
  logic [1:0]       op_sel [NREQ];

  logic             found;
  logic [IDW-1:0]   win;
  logic             can_accept;
  logic             grant_en;
  logic [WIDTH-1:0] lu_res;

  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      op_a[i]   = opA[i*WIDTH +: WIDTH];
      op_b[i]   = opB[i*WIDTH +: WIDTH];
      op_sel[i] = opSel[i*2 +: 2];
    end
  end

  // First pending request at or after ptr_q, wrapping modulo NREQ.
  always_comb begin
    int unsigned    idx;
    logic [IDW-1:0] idx_w;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    idx_w = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = {{(32-IDW){1'b0}}, ptr_q} + k;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end
      idx_w = idx[IDW-1:0];
      if (!found && req[idx_w]) begin
        found = 1'b1;
        win   = idx_w;
      end
    end
  end

  assign can_accept = (state_q == StEmpty) || resReady;
  assign grant_en   = !reset && can_accept && found;

  always_comb begin
    gnt = '0;
    if (grant_en) begin
      gnt[win] = 1'b1;
    end
  end

  always_comb begin
    lu_res = '0;
    unique case (op_sel[win])
      2'b00: lu_res = op_a[win] & op_b[win];
      2'b01: lu_res = op_a[win] | op_b[win];
      2'b10: lu_res = op_a[win] ^ op_b[win];
      2'b11: lu_res = ~(op_a[win] | op_b[win]);
    endcase
  end

  // An accept always (re)loads the slot, so a drain and an accept in the same cycle
  // keep it full with no bubble.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    res_id_d = res_id_q;
    ptr_d    = ptr_q;
    if (grant_en) begin
      state_d  = StFull;
      result_d = lu_res;
      res_id_d = win;
      ptr_d    = (win == IDW'(NREQ - 1)) ? '0 : win + IDW'(1);
    end else if ((state_q == StFull) && resReady) begin
      state_d = StEmpty;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StEmpty;
      result_q <= '0;
      res_id_q <= '0;
      ptr_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      res_id_q <= res_id_d;
      ptr_q    <= ptr_d;
    end
  end

  assign resValid = (state_q == StFull);
  assign resId    = res_id_q;
  assign result   = result_q;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Bench for logic_unit_arbiter: directed table, hand-written corner sequences and
// randomized traffic, all checked against a cycle-level reference model.
module tb_logic_unit_arbiter;

  localparam int W = 64;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [N*W-1:0] opA, opB;
  logic [2*N-1:0] opSel;
  logic           resReady;
  logic [N-1:0]   gnt;
  logic           resValid;
  logic [1:0]     resId;
  logic [W-1:0]   result;

  always #5 clk = ~clk;

  logic_unit_arbiter #(.WIDTH(W), .NREQ(N)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .opA      (opA),
    .opB      (opB),
    .opSel    (opSel),
    .gnt      (gnt),
    .resValid (resValid),
    .resReady (resReady),
    .resId    (resId),
    .result   (result)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  bit          m_known = 1'b0;
  logic        m_valid = 1'b0;
  logic [63:0] m_result = '0;
  int          m_id = 0;
  int          m_ptr = 0;
  logic [3:0]  gnt_seen;

  typedef struct {
    logic [3:0]  req;
    logic [1:0]  sel;
    logic [63:0] a;
    logic [63:0] b;
    logic [3:0]  exp_gnt;
    logic [1:0]  exp_id;
    logic [63:0] exp_res;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] lu(input logic [1:0] s, input logic [63:0] a,
                                     input logic [63:0] b);
    case (s)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~(a | b);
    endcase
  endfunction

  task automatic set_req_ops(input int i, input logic [1:0] s, input logic [63:0] a,
                             input logic [63:0] b);
    opA[i*W +: W]  = a;
    opB[i*W +: W]  = b;
    opSel[2*i +: 2] = s;
  endtask

  task automatic set_all(input logic [1:0] s, input logic [63:0] a, input logic [63:0] b);
    for (int i = 0; i < N; i++) set_req_ops(i, s, a, b);
  endtask

  // Inputs are already driven (just after a negedge). Check, clock, update model.
  task automatic cycle();
    int         w;
    int         i;
    logic [3:0] eg;
    #2;
    eg = '0;
    w  = -1;
    if (!reset) begin
      for (int k = 0; k < N; k++) begin
        i = (m_ptr + k) % N;
        if (w < 0 && req[i]) w = i;
      end
      if ((!m_valid || resReady) && w >= 0) eg[w] = 1'b1;
    end
    gnt_seen = gnt;
    check("gnt", 64'(gnt), 64'(eg));
    if (m_known) begin
      check("resValid", 64'(resValid), 64'(m_valid));
      check("resId", 64'(resId), 64'(m_id));
      check("result", result, m_result);
    end
    @(posedge clk);
    if (reset) begin
      m_known  = 1'b1;
      m_valid  = 1'b0;
      m_result = '0;
      m_id     = 0;
      m_ptr    = 0;
    end else if (eg != 4'b0) begin
      m_result = lu(opSel[2*w +: 2], opA[w*W +: W], opB[w*W +: W]);
      m_id     = w;
      m_valid  = 1'b1;
      m_ptr    = (w + 1) % N;
    end else if (m_valid && resReady) begin
      m_valid = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    logic [3:0] eg;

    tbl[0] = '{4'b0010, 2'b10, 64'h00FF_00FF_00FF_00FF, 64'h0F0F_0F0F_0F0F_0F0F,
               4'b0010, 2'd1, 64'h0FF0_0FF0_0FF0_0FF0};
    tbl[1] = '{4'b1000, 2'b00, 64'hFFFF_0000_FFFF_0000, 64'hFF00_FF00_FF00_FF00,
               4'b1000, 2'd3, 64'hFF00_0000_FF00_0000};
    tbl[2] = '{4'b1000, 2'b01, 64'hFFFF_0000_FFFF_0000, 64'hFF00_FF00_FF00_FF00,
               4'b1000, 2'd3, 64'hFFFF_FF00_FFFF_FF00};
    tbl[3] = '{4'b1000, 2'b11, 64'hFFFF_0000_FFFF_0000, 64'hFF00_FF00_FF00_FF00,
               4'b1000, 2'd3, 64'h0000_00FF_0000_00FF};
    tbl[4] = '{4'b1001, 2'b10, 64'hFFFF_0000_FFFF_0000, 64'hFF00_FF00_FF00_FF00,
               4'b0001, 2'd0, 64'h00FF_FF00_00FF_FF00};
    tbl[5] = '{4'b1111, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234_5678_9ABC_DEF0,
               4'b0010, 2'd1, 64'h1234_5678_9ABC_DEF0};
    tbl[6] = '{4'b1111, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234_5678_9ABC_DEF0,
               4'b0100, 2'd2, 64'h1234_5678_9ABC_DEF0};
    tbl[7] = '{4'b1111, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234_5678_9ABC_DEF0,
               4'b1000, 2'd3, 64'h1234_5678_9ABC_DEF0};

    // Reset held two cycles with all requests pending
    reset    = 1'b1;
    req      = 4'b1111;
    resReady = 1'b1;
    opA      = '0;
    opB      = '0;
    opSel    = '0;
    cycle();
    check("rst_gnt0", 64'(gnt_seen), 64'd0);
    cycle();
    check("rst_gnt1", 64'(gnt_seen), 64'd0);
    reset = 1'b0;
    req   = '0;
    check("rst_valid", 64'(resValid), 64'd0);
    check("rst_id", 64'(resId), 64'd0);
    check("rst_result", result, 64'd0);

    // Directed ops, wrap and pointer progression
    for (int t = 0; t < 8; t++) begin
      req = tbl[t].req;
      set_all(tbl[t].sel, tbl[t].a, tbl[t].b);
      resReady = 1'b1;
      cycle();
      check("tbl_gnt", 64'(gnt_seen), 64'(tbl[t].exp_gnt));
      check("tbl_valid", 64'(resValid), 64'd1);
      check("tbl_id", 64'(resId), 64'(tbl[t].exp_id));
      check("tbl_res", result, tbl[t].exp_res);
    end
    req = '0;
    cycle();
    check("drain_valid", 64'(resValid), 64'd0);

    // Round-robin from a fresh pointer
    do_reset();
    req = 4'b1111;
    set_all(2'b01, 64'h0000_1111_2222_3333, 64'h4444_0000_0000_0000);
    for (int k = 0; k < 5; k++) begin
      eg = 4'b0001 << (k % 4);
      cycle();
      check("rr_gnt", 64'(gnt_seen), 64'(eg));
      check("rr_id", 64'(resId), 64'(k % 4));
    end

    // Backpressure, then reload with no bubble
    do_reset();
    req = 4'b0001;
    set_req_ops(0, 2'b10, 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555);
    cycle();
    check("bp_first_gnt", 64'(gnt_seen), 64'b0001);
    req = 4'b0100;
    set_req_ops(2, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0123_4567_89AB_CDEF);
    resReady = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("bp_gnt", 64'(gnt_seen), 64'd0);
      check("bp_valid", 64'(resValid), 64'd1);
      check("bp_id", 64'(resId), 64'd0);
      check("bp_res", result, 64'hFFFF_FFFF_FFFF_FFFF);
    end
    resReady = 1'b1;
    cycle();
    check("bp_release_gnt", 64'(gnt_seen), 64'b0100);
    check("bp_reload_valid", 64'(resValid), 64'd1);
    check("bp_reload_id", 64'(resId), 64'd2);
    check("bp_reload_res", result, 64'h0123_4567_89AB_CDEF);
    req = '0;
    cycle();
    check("bp_drain_valid", 64'(resValid), 64'd0);

    // Reset while a result is held and the pointer sits at 2
    do_reset();
    req = 4'b0010;
    resReady = 1'b1;
    cycle();
    req = '0;
    resReady = 1'b0;
    cycle();
    check("mr_held_valid", 64'(resValid), 64'd1);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("mr_valid", 64'(resValid), 64'd0);
    req = 4'b1111;
    resReady = 1'b1;
    cycle();
    check("mr_gnt", 64'(gnt_seen), 64'b0001);

    // Randomized traffic against the model
    for (int t = 0; t < 400; t++) begin
      reset    = ($urandom_range(0, 39) == 0);
      req      = 4'($urandom);
      resReady = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        set_req_ops(i, 2'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
      end
      cycle();
    end
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
